// File: rtl/mbledhesi_pkg.sv
// Shared types and elaboration helpers for the serial adder.
package mbledhesi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of the chunk counter: enough bits to count WIDTH/CHUNK steps, never below one bit.
   function automatic int cnt_width(input int width, input int chunk);
      int n;
      n = width / chunk;
      if (n <= 32'sd1) begin
         return 32'sd1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/mbledhesi_chunk.sv
// Combinational W-bit ripple adder built from per-bit full adders.
module mbledhesi_chunk #(
   parameter int W = 1
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   logic [W:0] c_s;

   assign c_s[0] = ci;

   for (genvar i = 0; i < W; i++) begin : g_fa
      assign s[i]     = x[i] ^ y[i] ^ c_s[i];
      assign c_s[i+1] = (x[i] & y[i]) | (c_s[i] & (x[i] ^ y[i]));
   end

   assign co = c_s[W];

endmodule

// File: rtl/mbledhesi_serial.sv
// Multi-cycle adder: CHUNK bits per clock, start/busy/done handshake,
// reports sum, unsigned carry-out and two's-complement overflow.
module mbledhesi_serial
   import mbledhesi_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = cnt_width(WIDTH, CHUNK);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 32'sd1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(32'sd1);

   if ((WIDTH < 2) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
      $error("mbledhesi_serial: WIDTH must be >= 2 and divisible by CHUNK");
   end

   state_t           state_r;
   state_t           state_nx_s;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic [WIDTH-1:0] sum_r;
   logic [WIDTH-1:0] sum_nx_s;
   logic             carry_r;
   logic             a_msb_r;
   logic             b_msb_r;
   logic             cout_r;
   logic             ovf_r;
   logic             busy_r;
   logic             done_r;
   logic [CHUNK-1:0] csum_s;
   logic             cco_s;
   logic             accept_s;
   logic             last_s;

   // A new operation is taken whenever the unit is not mid-run.
   assign accept_s = start && (state_r != RUN);
   assign last_s   = (state_r == RUN) && (cnt_r == CNT_LAST);

   mbledhesi_chunk #(
      .W (CHUNK)
   ) u_chunk (
      .x  (a_sh_r[CHUNK-1:0]),
      .y  (b_sh_r[CHUNK-1:0]),
      .ci (carry_r),
      .s  (csum_s),
      .co (cco_s)
   );

   // New chunk enters at the MSB end; with a single chunk the whole word is replaced.
   if (CHUNK == WIDTH) begin : g_sum_full
      assign sum_nx_s = csum_s;
   end else begin : g_sum_shift
      assign sum_nx_s = {csum_s, sum_r[WIDTH-1:CHUNK]};
   end

   // Next-state logic for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nx_s = RUN;
            end else begin
               state_nx_s = IDLE;
            end
         end
         RUN: begin
            if (cnt_r == CNT_LAST) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = RUN;
            end
         end
         DONE: begin
            if (start) begin
               state_nx_s = RUN;
            end else begin
               state_nx_s = IDLE;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Handshake flags registered from the next state so they align with the state itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_nx_s == RUN);
         done_r <= (state_nx_s == DONE);
      end
   end

   // Operand capture, per-chunk shifting, carry propagation and step counting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_r  <= {WIDTH{1'b0}};
         b_sh_r  <= {WIDTH{1'b0}};
         sum_r   <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         a_msb_r <= 1'b0;
         b_msb_r <= 1'b0;
         cnt_r   <= {CW{1'b0}};
      end else if (accept_s) begin
         a_sh_r  <= a;
         b_sh_r  <= b;
         carry_r <= cin;
         a_msb_r <= a[WIDTH-1];
         b_msb_r <= b[WIDTH-1];
         cnt_r   <= {CW{1'b0}};
      end else if (state_r == RUN) begin
         a_sh_r  <= a_sh_r >> CHUNK;
         b_sh_r  <= b_sh_r >> CHUNK;
         sum_r   <= sum_nx_s;
         carry_r <= cco_s;
         cnt_r   <= cnt_r + CNT_ONE;
      end
   end

   // Carry-out and overflow are committed on the final chunk and held until the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cout_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else if (last_s) begin
         cout_r <= cco_s;
         ovf_r  <= (a_msb_r == b_msb_r) && (csum_s[CHUNK-1] != a_msb_r);
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign sum      = sum_r;
   assign cout     = cout_r;
   assign overflow = ovf_r;

endmodule

// File: doc/mbledhesi_serial.md
Name: mbledhesi_serial

Overview:
Parametrised multi-cycle adder for WIDTH-bit operands.
- Processes CHUNK bits per clock through a CHUNK-bit ripple stage that carries its result into the next cycle.
- Uses a start/busy/done handshake.
- Reports sum, carry-out and signed overflow.
- Serves as the area-lean arithmetic unit for datapaths where operands arrive at low rate and a full-width combinational adder is too costly.

Parameters:
- WIDTH, 8: operand and sum width in bits; must be ≥ 2.
- CHUNK, 1: bits added per clock. Must divide WIDTH exactly; otherwise elaboration fails.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request. Sampled on a rising edge only while the state is IDLE or DONE.
- a  in  WIDTH  operand A. Captured on the accepting edge.
- b  in  WIDTH  operand B. Captured on the accepting edge.
- cin  in  1  carry-in. Captured on the accepting edge.
- busy  out  1  high while state is RUN.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- sum  out  WIDTH  result, (a + b + cin) mod 2^WIDTH.
- cout  out  1  unsigned carry out of the MSB.
- overflow  out  1  two's-complement overflow.

Behaviour:
- States:
  - IDLE → RUN on start.
  - RUN → DONE after N = WIDTH/CHUNK processing edges.
  - DONE → RUN if start is high, else DONE → IDLE.
- Reset (async, rst_n=0): state=IDLE, counter=0, busy=0, done=0, sum=0, cout=0, overflow=0, internal carry=0. Reset asserted mid-RUN aborts the operation, and no done pulse is produced for it.
- Accept edge (start=1 in IDLE or DONE):
  - Load a and b into shift registers, and load cin into the carry flop.
  - Latch a[WIDTH-1] and b[WIDTH-1] for the overflow calculation.
  - Clear the counter. The next state is RUN.
- start while in RUN is ignored. Operand changes during RUN have no effect.
- Each RUN edge:
  - The CHUNK LSBs of the A and B shift registers, plus the carry flop, feed the chunk adder.
  - The chunk sum shifts into the MSB end of the sum register, which is right-shifted by CHUNK.
  - The A and B shift registers right-shift by CHUNK.
  - The chunk carry-out is stored in the carry flop, and the counter increments.
- On the RUN edge where counter == N-1:
  - The state moves to DONE.
  - cout = final chunk carry.
  - overflow = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb).
- Latency: if start is accepted at edge k, busy=1 after edge k through edge k+N-1. The done pulse is high for exactly one cycle after edge k+N.
- Hold: sum, cout and overflow hold their last values until the next accepted operation's final edge. Within RUN, sum shows the partial shift contents, and consumers must use done.
- Back-to-back: start=1 during the DONE cycle is accepted. busy rises the cycle after done, giving no idle gap; throughput is one result per N+1 cycles.
- Wrap-around: all arithmetic is modulo 2^WIDTH. There is no saturation.
- CHUNK == WIDTH is legal: N=1 and done follows one edge after busy.

Decomposition:
- Package mbledhesi_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Counter-width function clog2(WIDTH/CHUNK), with a minimum of 1.
- Sub-module mbledhesi_chunk:
  - Parameter W (=CHUNK).
  - Inputs x[W], y[W], ci; outputs s[W], co.
  - Purely combinational ripple of per-bit full adders, instantiated once in the datapath.
- The top module holds the FSM, counter, shift registers and result flops.

Test Plan:
- Carry chain (WIDTH=8, CHUNK=1): a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, overflow=0. done occurs exactly 8 edges after the accept edge; busy is high for 8 cycles.
- Signed overflow (WIDTH=8, CHUNK=1): a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, overflow=1. Also a=0x80, b=0x80 → sum=0x00, cout=1, overflow=1.
- Chunked mode (WIDTH=8, CHUNK=4): a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1, overflow=0, with done 2 edges after accept.
- Mid-operation reset: start a=0x12, b=0x34, pull rst_n low after 3 RUN edges → all outputs are 0 immediately, state=IDLE, and no done pulse. A subsequent start with a=0x03, b=0x04 → sum=0x07.
- Busy and back-to-back:
  - Hold start=1 continuously with a=0x10, b=0x20 changing to a=0x01, b=0x01 mid-RUN → the first result is 0x30, and mid-RUN operand changes are ignored.
  - Second operation is accepted in the DONE cycle → result 0x02, with done pulses separated by exactly N+1 cycles.
- Random sweep: WIDTH ∈ {8, 16}, CHUNK ∈ {1, 2, 4, WIDTH}. 1000 random a, b, cin compared against a reference model on done; protocol checks confirm that done is a single-cycle pulse and that busy and done are never high together.
